// File: rtl/alu_pkg.sv
// Shared encodings for the ALU writeback path: condition codes, PC register index
// and writeback buffer states.
package alu_pkg;

    localparam logic [1:0] COND_ALWAYS = 2'b00;
    localparam logic [1:0] COND_Z      = 2'b10;
    localparam logic [1:0] COND_C      = 2'b01;

    localparam logic [2:0] REG_PC = 3'd7;

    typedef enum logic {
        EMPTY = 1'b0,
        FULL  = 1'b1
    } wb_state_t;

endpackage

// File: rtl/flag_cond_eval.sv
// Combinational condition check and next carry/zero flag computation.
// The branch unit will reuse this block.
module flag_cond_eval
    import alu_pkg::*;
#(
    parameter int DW = 16
) (
    input  logic [1:0]    cond,
    input  logic          is_nand,
    input  logic [DW-1:0] result,
    input  logic          carry,
    input  logic          flag_c,
    input  logic          flag_z,
    output logic          exec,
    output logic          flag_c_nxt,
    output logic          flag_z_nxt
);

    always_comb begin
        exec = (cond == COND_ALWAYS)
             | ((cond == COND_Z) & flag_z)
             | ((cond == COND_C) & flag_c);
        flag_z_nxt = exec ? (result == '0) : flag_z;
        // NAND results never touch the carry flag.
        flag_c_nxt = (exec & ~is_nand) ? carry : flag_c;
    end

endmodule

// File: rtl/alu_writeback.sv
// Execute-to-writeback stage: owns the C/Z flags, buffers one register-file
// write, raises pc_load for R7 writes and counts retired/skipped packets.
module alu_writeback
    import alu_pkg::*;
#(
    parameter int DW = 16,
    parameter int AW = 3,
    parameter int CW = 16
) (
    input  logic          clk,
    input  logic          reset,
    input  logic          in_valid,
    output logic          in_ready,
    input  logic [DW-1:0] in_result,
    input  logic          in_carry,
    input  logic          in_is_nand,
    input  logic [1:0]    in_cond,
    input  logic [AW-1:0] in_rd,
    input  logic          rf_busy,
    output logic          rf_we,
    output logic [AW-1:0] rf_addr,
    output logic [DW-1:0] rf_wdata,
    output logic          pc_load,
    output logic          flag_c,
    output logic          flag_z,
    output logic [CW-1:0] retired_cnt,
    output logic [CW-1:0] skipped_cnt
);

    wb_state_t     state_q, state_d;
    logic [AW-1:0] addr_q, addr_d;
    logic [DW-1:0] data_q, data_d;
    logic          pc_load_q, pc_load_d;
    logic          flag_c_q, flag_c_d;
    logic          flag_z_q, flag_z_d;
    logic [CW-1:0] retired_q, retired_d;
    logic [CW-1:0] skipped_q, skipped_d;

    logic accept;
    logic exec;
    logic wb_fire;
    logic flag_c_nxt;
    logic flag_z_nxt;

    flag_cond_eval #(.DW(DW)) u_flag_cond_eval (
        .cond       (in_cond),
        .is_nand    (in_is_nand),
        .result     (in_result),
        .carry      (in_carry),
        .flag_c     (flag_c_q),
        .flag_z     (flag_z_q),
        .exec       (exec),
        .flag_c_nxt (flag_c_nxt),
        .flag_z_nxt (flag_z_nxt)
    );

    assign in_ready = (state_q == EMPTY) | ~rf_busy;
    assign accept   = in_valid & in_ready;
    assign wb_fire  = accept & exec;

    always_comb begin
        // A stalled FULL buffer holds; otherwise a new executed packet refills it.
        if (wb_fire) begin
            state_d = FULL;
        end else if ((state_q == FULL) && rf_busy) begin
            state_d = FULL;
        end else begin
            state_d = EMPTY;
        end
        addr_d    = wb_fire ? in_rd : addr_q;
        data_d    = wb_fire ? in_result : data_q;
        pc_load_d = (state_d == FULL) && (addr_d == AW'(REG_PC));
        flag_c_d  = accept ? flag_c_nxt : flag_c_q;
        flag_z_d  = accept ? flag_z_nxt : flag_z_q;
        retired_d = retired_q + CW'(wb_fire);
        skipped_d = skipped_q + CW'(accept & ~exec);
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q   <= EMPTY;
            addr_q    <= '0;
            data_q    <= '0;
            pc_load_q <= 1'b0;
            flag_c_q  <= 1'b0;
            flag_z_q  <= 1'b0;
            retired_q <= '0;
            skipped_q <= '0;
        end else begin
            state_q   <= state_d;
            addr_q    <= addr_d;
            data_q    <= data_d;
            pc_load_q <= pc_load_d;
            flag_c_q  <= flag_c_d;
            flag_z_q  <= flag_z_d;
            retired_q <= retired_d;
            skipped_q <= skipped_d;
        end
    end

    assign rf_we       = (state_q == FULL);
    assign rf_addr     = addr_q;
    assign rf_wdata    = data_q;
    assign pc_load     = pc_load_q;
    assign flag_c      = flag_c_q;
    assign flag_z      = flag_z_q;
    assign retired_cnt = retired_q;
    assign skipped_cnt = skipped_q;

endmodule

// File: tb/tb_alu_writeback.sv
// Bench for alu_writeback: directed scenarios with literal expectations, then
// randomized traffic checked every cycle against a behavioural model.
module tb_alu_writeback;

    localparam int DW = 16;
    localparam int AW = 3;
    localparam int CW = 4;

    logic          clk = 1'b0;
    logic          reset;
    logic          in_valid;
    logic          in_ready;
    logic [DW-1:0] in_result;
    logic          in_carry;
    logic          in_is_nand;
    logic [1:0]    in_cond;
    logic [AW-1:0] in_rd;
    logic          rf_busy;
    logic          rf_we;
    logic [AW-1:0] rf_addr;
    logic [DW-1:0] rf_wdata;
    logic          pc_load;
    logic          flag_c;
    logic          flag_z;
    logic [CW-1:0] retired_cnt;
    logic [CW-1:0] skipped_cnt;

    alu_writeback #(.DW(DW), .AW(AW), .CW(CW)) dut (
        .clk         (clk),
        .reset       (reset),
        .in_valid    (in_valid),
        .in_ready    (in_ready),
        .in_result   (in_result),
        .in_carry    (in_carry),
        .in_is_nand  (in_is_nand),
        .in_cond     (in_cond),
        .in_rd       (in_rd),
        .rf_busy     (rf_busy),
        .rf_we       (rf_we),
        .rf_addr     (rf_addr),
        .rf_wdata    (rf_wdata),
        .pc_load     (pc_load),
        .flag_c      (flag_c),
        .flag_z      (flag_z),
        .retired_cnt (retired_cnt),
        .skipped_cnt (skipped_cnt)
    );

    always #5 clk = ~clk;

    int vectors     = 0;
    int miscompares = 0;

    // Behavioural model state
    bit          m_pend;
    bit [AW-1:0] m_addr;
    bit [DW-1:0] m_data;
    bit          m_c, m_z;
    int          m_ret, m_skp, m_writes;
    int          dut_writes = 0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        vectors++;
        if (act !== exp) begin
            miscompares++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic model_step();
        bit rdy, ex;
        if (reset) begin
            m_pend = 0; m_addr = '0; m_data = '0;
            m_c = 0; m_z = 0; m_ret = 0; m_skp = 0;
        end else begin
            rdy = !m_pend || !rf_busy;
            if (m_pend && !rf_busy) begin
                m_pend = 0;
                m_writes++;
            end
            if (in_valid && rdy) begin
                case (in_cond)
                    2'b00:   ex = 1;
                    2'b10:   ex = m_z;
                    2'b01:   ex = m_c;
                    default: ex = 0;
                endcase
                if (ex) begin
                    m_z = (in_result == 0);
                    if (!in_is_nand) m_c = in_carry;
                    m_pend = 1; m_addr = in_rd; m_data = in_result;
                    m_ret++;
                end else begin
                    m_skp++;
                end
            end
        end
    endtask

    task automatic check_outputs();
        chk("rf_we", rf_we, m_pend);
        chk("pc_load", pc_load, m_pend && (m_addr == 3'd7));
        if (m_pend) begin
            chk("rf_addr", rf_addr, m_addr);
            chk("rf_wdata", rf_wdata, m_data);
        end
        chk("flag_c", flag_c, m_c);
        chk("flag_z", flag_z, m_z);
        chk("retired_cnt", retired_cnt, m_ret % (1 << CW));
        chk("skipped_cnt", skipped_cnt, m_skp % (1 << CW));
    endtask

    // Called at a falling edge with inputs already driven.
    task automatic tick();
        #1;
        if (!reset) begin
            chk("in_ready", in_ready, !m_pend || !rf_busy);
            if (rf_we && !rf_busy) dut_writes++;
        end
        @(posedge clk);
        model_step();
        @(negedge clk);
        check_outputs();
    endtask

    task automatic drive(input bit v, input logic [DW-1:0] res, input bit cy,
                         input bit nd, input logic [1:0] cd, input logic [AW-1:0] rd);
        in_valid = v; in_result = res; in_carry = cy;
        in_is_nand = nd; in_cond = cd; in_rd = rd;
    endtask

    int w0;

    initial begin
        reset = 1; rf_busy = 0;
        drive(0, '0, 0, 0, 2'b00, '0);
        tick();
        tick();
        reset = 0;
        tick();
        #1;
        chk("rst_in_ready", in_ready, 1);
        chk("rst_rf_we", rf_we, 0);
        chk("rst_flags", {flag_c, flag_z}, 0);
        chk("rst_counts", {retired_cnt, skipped_cnt}, 0);

        // ADD 0x7FFF + 1
        drive(1, 16'h8000, 0, 0, 2'b00, 3'd3);
        tick();
        chk("add_we", rf_we, 1);
        chk("add_addr", rf_addr, 3);
        chk("add_data", rf_wdata, 16'h8000);
        chk("add_cz", {flag_c, flag_z}, 2'b00);
        chk("add_ret", retired_cnt, 1);

        // ADD 0xFFFF + 1 then ADC back-to-back
        drive(1, 16'h0000, 1, 0, 2'b00, 3'd1);
        tick();
        chk("add0_cz", {flag_c, flag_z}, 2'b11);
        drive(1, 16'h1234, 0, 0, 2'b01, 3'd2);
        tick();
        chk("adc_we", rf_we, 1);
        chk("adc_addr", rf_addr, 2);
        chk("adc_data", rf_wdata, 16'h1234);
        chk("adc_cz", {flag_c, flag_z}, 2'b00);
        chk("adc_ret", retired_cnt, 3);

        // ADZ with Z=0 is skipped
        drive(1, 16'h0005, 1, 0, 2'b10, 3'd4);
        #1;
        chk("adz_ready", in_ready, 1);
        tick();
        chk("adz_we", rf_we, 0);
        chk("adz_skp", skipped_cnt, 1);
        chk("adz_cz", {flag_c, flag_z}, 2'b00);

        // NDU with result 0 keeps C=1
        drive(1, 16'h0001, 1, 0, 2'b00, 3'd5);
        tick();
        drive(1, 16'h0000, 0, 1, 2'b00, 3'd6);
        tick();
        chk("ndu_cz", {flag_c, flag_z}, 2'b11);
        chk("ndu_addr", rf_addr, 6);

        // R7 write held through three busy cycles
        drive(1, 16'h0040, 0, 0, 2'b00, 3'd7);
        tick();
        drive(0, '0, 0, 0, 2'b00, '0);
        rf_busy = 1;
        w0 = dut_writes;
        for (int i = 0; i < 3; i++) begin
            #1;
            chk("stall_we", rf_we, 1);
            chk("stall_pc", pc_load, 1);
            chk("stall_data", rf_wdata, 16'h0040);
            chk("stall_ready", in_ready, 0);
            tick();
        end
        rf_busy = 0;
        #1;
        chk("stall_we4", rf_we, 1);
        chk("stall_pc4", pc_load, 1);
        tick();
        chk("stall_writes", dut_writes - w0, 1);
        chk("stall_done", {rf_we, pc_load}, 2'b00);

        // Reset while FULL and stalled
        drive(1, 16'h0099, 1, 0, 2'b00, 3'd1);
        tick();
        drive(0, '0, 0, 0, 2'b00, '0);
        rf_busy = 1;
        reset = 1;
        w0 = dut_writes;
        tick();
        chk("rstf_we", rf_we, 0);
        chk("rstf_flags", {flag_c, flag_z}, 0);
        chk("rstf_counts", {retired_cnt, skipped_cnt}, 0);
        reset = 0; rf_busy = 0;
        tick();
        tick();
        chk("rstf_nowrite", dut_writes - w0, 0);
        chk("rstf_we2", rf_we, 0);

        // Randomized traffic
        for (int n = 0; n < 3000; n++) begin
            reset      = ($urandom_range(0, 199) == 0);
            rf_busy    = ($urandom_range(0, 9) < 3);
            drive($urandom_range(0, 3) != 0,
                  ($urandom_range(0, 3) == 0) ? 16'h0000 : DW'($urandom),
                  1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)),
                  2'($urandom_range(0, 3)), AW'($urandom_range(0, 7)));
            tick();
        end
        reset = 0; rf_busy = 0;
        drive(0, '0, 0, 0, 2'b00, '0);
        tick();
        tick();
        chk("total_writes", dut_writes, m_writes);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule

// File: doc/alu_writeback.md
# alu_writeback

Execute-to-writeback stage that sits directly downstream of the 16-bit ALU in the multicycle datapath. It accepts one ALU result per handshake, evaluates the instruction's condition against the architectural carry/zero flag register it owns, and updates the flags. It then drives a one-entry buffered register-file write port, signals a PC load when R7 is the destination, and keeps retire/skip counters for debug.

## Interface
Parameters:
- `DW`, 16: datapath width.
- `AW`, 3: register address width (R0–R7).
- `CW`, 16: width of each debug counter.

Ports:
- `clk`, in, 1: clock; all state changes on its rising edge.
- `reset`, in, 1: synchronous, active-high reset.
- `in_valid`, in, 1: result packet valid.
- `in_ready`, out, 1: stage can accept a packet.
- `in_result`, in, DW: ALU output.
- `in_carry`, in, 1: ALU carry-out (bit DW of the unsigned add); ignored for NAND.
- `in_is_nand`, in, 1: 0 = add class (ADD/ADC/ADZ/ADI), 1 = NAND class (NDU/NDC/NDZ).
- `in_cond`, in, 2: 00 unconditional, 10 execute if Z, 01 execute if C, 11 reserved (treated as never).
- `in_rd`, in, AW: destination register.
- `rf_busy`, in, 1: register file cannot take a write this cycle.
- `rf_we`, out, 1: write enable.
- `rf_addr`, out, AW: write address.
- `rf_wdata`, out, DW: write data.
- `pc_load`, out, 1: pulses with `rf_we` when `rf_addr == 7`.
- `flag_c`, out, 1: architectural carry flag.
- `flag_z`, out, 1: architectural zero flag.
- `retired_cnt`, out, CW: number of executed packets.
- `skipped_cnt`, out, CW: number of condition-failed packets.

## Operation
- Accept: a packet is accepted on a rising edge when `in_valid && in_ready`.
- Execute condition: `exec = (cond==00) | (cond==10 & flag_z) | (cond==01 & flag_c)`. It uses the flag register value before the accept edge.
- Flags when `exec` is set:
  - `flag_z <= (in_result == 0)`.
  - `flag_c <= in_carry`, for the add class only.
  - NAND class leaves C unchanged.
- Flags when `exec` is clear: both flags unchanged.
- Write buffer when `exec` is set: the accept loads a one-entry write buffer (`pend`, addr, data) and increments `retired_cnt`.
- Skipped packets: no write, `skipped_cnt` increments, and the buffer is untouched.
- FSM, two states:
  - EMPTY: `rf_we = 0`. Accepting an executed packet moves to FULL.
  - FULL: `rf_we = 1`, holding addr and data. If `rf_busy == 0`, the write completes this cycle. At that edge the FSM goes to EMPTY, or stays FULL if a new executed packet is accepted on the same edge; in that case the buffer is replaced. If `rf_busy == 1`, the FSM stays FULL and `rf_we`, addr and data stay stable.
- `in_ready = (state==EMPTY) | ~rf_busy`.
- Counters wrap modulo 2^CW. No saturation.
- Reset values:
  - state EMPTY; `rf_we`, `pc_load`, `flag_c`, `flag_z` all 0.
  - `rf_addr` 0, `rf_wdata` 0, both counters 0.
  - `in_ready` 1 once reset deasserts.
- Reset mid-operation: a buffered, unwritten result is discarded and no write is issued. Reset takes priority over any accept in the same cycle.

## Timing
- Latency: a packet accepted at edge T drives `rf_we` during cycle T+1 (registered outputs; no combinational path from `in_*` to `rf_*`).
- Flags for a packet accepted at T are visible from T+1. A conditional packet accepted at T+1 therefore sees the flags produced by the packet at T, with no bubble.
- Throughput: one packet per cycle while `rf_busy` stays low.
- Stalls: each `rf_busy` cycle adds one cycle. `in_ready` drops combinationally with `rf_busy` only while FULL.
- `pc_load` is exactly coincident with `rf_we` and held identically during stalls.

## Structure
- A shared package `alu_pkg` holds:
  - cond encodings `COND_ALWAYS = 2'b00`, `COND_Z = 2'b10`, `COND_C = 2'b01`;
  - `REG_PC = 3'd7`;
  - the `wb_state_t` enum (EMPTY, FULL).
- Sub-module `flag_cond_eval`: combinational evaluation of `exec` and the next flag values from (cond, is_nand, result, carry, flags). It is reused by the later flag-aware branch unit.
- Counters and the write buffer stay in the top level.

## Test plan
- Reset, then ADD of 0x7FFF + 0x0001: result 0x8000, carry 0, rd=3. Expect `rf_we` one cycle later, addr 3, data 0x8000, C=0, Z=0, `retired_cnt` = 1.
- ADD 0xFFFF + 0x0001 (result 0, carry 1), then on the next cycle ADC (cond 01) with result 0x1234, rd=2. Expect the ADC executes with no bubble and writes 0x1234; C=0, Z=0.
- With Z=0, send ADZ (cond 10). Expect no `rf_we`, flags unchanged, `skipped_cnt` = 1, `in_ready` stays 1.
- NDU with result 0x0000 while C=1. Expect Z=1, C=1 unchanged.
- Hold `rf_busy` high for 3 cycles with a pending write to rd=7, data 0x0040. Expect `rf_we` and `pc_load` held stable for 4 cycles with data unchanged, `in_ready` = 0 during the busy cycles, and exactly one completed write.
- Assert `reset` while FULL and `rf_busy` = 1. Expect `rf_we` = 0 the next cycle, all flags and counters 0, and the pending write never issued.
